// File: rtl/r16_wb_agu.sv
// Write-back address generator for the radix-16 FFT: delays read-side bank/address/stage
// tags by the butterfly latency, issues per-bank write strobes and tracks stage/FFT completion.
module r16_wb_agu #(
  parameter int A_WIDTH    = 11,
  parameter int LAT        = 48,
  parameter int PTS_STAGE  = 4096,
  parameter int WC_WIDTH   = 13,
  parameter int NUM_STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               rd_en,
  input  logic               rd_bn,
  input  logic [A_WIDTH-1:0] rd_ma,
  input  logic [1:0]         rd_stage,
  output logic               wr_en0,
  output logic               wr_en1,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [1:0]         wr_stage,
  output logic               stage_done,
  output logic               fft_done,
  output logic               busy,
  output logic               stage_err
);

  localparam int                  IF_W    = $clog2(LAT + 1);
  localparam logic [WC_WIDTH-1:0] WC_LAST = WC_WIDTH'(PTS_STAGE - 1);
  localparam logic [1:0]          SC_LAST = 2'(NUM_STAGES - 1);

  typedef struct packed {
    logic               en;
    logic               bn;
    logic [A_WIDTH-1:0] ma;
    logic [1:0]         stage;
  } ent_t;

  ent_t dl_q [LAT];
  ent_t tap;

  logic                issue, accept, last_wr;
  logic [WC_WIDTH-1:0] wc_q, wc_d;
  logic [1:0]          sc_q, sc_d;
  logic [IF_W-1:0]     if_q, if_d;
  logic                err_q, err_d;

  logic               wr_en0_q, wr_en1_q, stage_done_q, fft_done_q, busy_q;
  logic [A_WIDTH-1:0] wr_addr_q;
  logic [1:0]         wr_stage_q;

  // The entry leaving the last delay slot is the write issued at this edge; the output
  // registers then make the total read-to-write latency exactly LAT edges.
  assign tap = dl_q[LAT-1];

  // NOTE: the delay line is plain flops, not a RAM, so it is reset; a stale en bit left in
  // it after reset would otherwise issue phantom writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= '{en: rd_en, bn: rd_bn, ma: rd_ma, stage: rd_stage};
      for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // NOTE: every variable gets its hold value first, so no path through this block can
  // leave one unassigned and infer a latch.
  always_comb begin
    accept  = rd_en & ~clr;
    issue   = tap.en & ~clr;
    last_wr = issue && (wc_q == WC_LAST);
    wc_d    = wc_q;
    sc_d    = sc_q;
    if_d    = if_q;
    err_d   = err_q;
    if (issue) begin
      wc_d = last_wr ? '0 : wc_q + 1'b1;
      if (last_wr) sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      if (tap.stage != sc_q) err_d = 1'b1;
    end
    if (accept && !issue)      if_d = if_q + IF_W'(1);
    else if (!accept && issue) if_d = if_q - IF_W'(1);
    if (clr) begin
      wc_d  = '0;
      sc_d  = '0;
      if_d  = '0;
      err_d = 1'b0;
    end
  end

  // NOTE: state and output registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_q         <= '0;
      sc_q         <= '0;
      if_q         <= '0;
      err_q        <= 1'b0;
      wr_en0_q     <= 1'b0;
      wr_en1_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_stage_q   <= '0;
      stage_done_q <= 1'b0;
      fft_done_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wc_q         <= wc_d;
      sc_q         <= sc_d;
      if_q         <= if_d;
      err_q        <= err_d;
      wr_en0_q     <= issue & ~tap.bn;
      wr_en1_q     <= issue & tap.bn;
      if (issue) wr_addr_q <= tap.ma;
      // wr_stage trails sc by one cycle so it changes after the final write of a stage.
      wr_stage_q   <= clr ? 2'd0 : sc_q;
      stage_done_q <= last_wr;
      fft_done_q   <= last_wr && (sc_q == SC_LAST);
      busy_q       <= (if_d != '0) || (wc_d != '0);
    end
  end

  assign wr_en0     = wr_en0_q;
  assign wr_en1     = wr_en1_q;
  assign wr_addr    = wr_addr_q;
  assign wr_stage   = wr_stage_q;
  assign stage_done = stage_done_q;
  assign fft_done   = fft_done_q;
  assign busy       = busy_q;
  assign stage_err  = err_q;

endmodule

// File: tb/tb_r16_wb_agu.sv
// Self-checking bench for r16_wb_agu: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_r16_wb_agu;

  localparam int AW  = 11;
  localparam int LAT = 4;
  localparam int PTS = 16;
  localparam int NS  = 4;

  logic          clk, rst_n, clr, rd_en, rd_bn;
  logic [AW-1:0] rd_ma;
  logic [1:0]    rd_stage;
  logic          wr_en0, wr_en1, stage_done, fft_done, busy, stage_err;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_stage;

  r16_wb_agu #(
    .A_WIDTH(AW), .LAT(LAT), .PTS_STAGE(PTS), .WC_WIDTH(5), .NUM_STAGES(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .rd_en(rd_en), .rd_bn(rd_bn), .rd_ma(rd_ma), .rd_stage(rd_stage),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_addr(wr_addr), .wr_stage(wr_stage),
    .stage_done(stage_done), .fft_done(fft_done), .busy(busy), .stage_err(stage_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each accepted word is queued with the edge number at which it must
  // be written; the stage and write counters follow from the total number of writes.
  typedef struct {
    int            due;
    logic          bn;
    logic [AW-1:0] ma;
    logic [1:0]    st;
  } word_t;

  word_t         q[$];
  word_t         w;
  int            cyc   = 0;
  int            total = 0;
  logic          e_en0 = 0, e_en1 = 0, e_sd = 0, e_fd = 0, e_busy = 0, e_err = 0;
  logic [AW-1:0] e_addr = 0;
  logic [1:0]    e_ws = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      total = 0;
      {e_en0, e_en1, e_sd, e_fd, e_busy, e_err} = '0;
      e_addr = '0;
      e_ws   = '0;
    end else if (clr) begin
      q.delete();
      total = 0;
      {e_en0, e_en1, e_sd, e_fd, e_busy, e_err} = '0;
      e_ws = '0;
    end else begin
      e_ws = 2'((total / PTS) % NS);
      {e_en0, e_en1, e_sd, e_fd} = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        w      = q.pop_front();
        e_en0  = !w.bn;
        e_en1  = w.bn;
        e_addr = w.ma;
        if (int'(w.st) != (total / PTS) % NS) e_err = 1'b1;
        total++;
        e_sd = (total % PTS) == 0;
        e_fd = (total % (PTS * NS)) == 0;
      end
      if (rd_en) q.push_back('{cyc + LAT, rd_bn, rd_ma, rd_stage});
      e_busy = (q.size() != 0) || (total % PTS != 0);
    end
    cyc++;
    #1;
    check("wr_en0", wr_en0, e_en0);
    check("wr_en1", wr_en1, e_en1);
    check("wr_addr", wr_addr, e_addr);
    check("wr_stage", wr_stage, e_ws);
    check("stage_done", stage_done, e_sd);
    check("fft_done", fft_done, e_fd);
    check("busy", busy, e_busy);
    check("stage_err", stage_err, e_err);
    check("strobe_excl", wr_en0 & wr_en1, 0);
  end

  // Apply one cycle of read-side inputs; returns 2 time units after the edge that took them.
  task automatic go(input logic en, input logic bn, input logic [AW-1:0] ma, input logic [1:0] st);
    rd_en    = en;
    rd_bn    = bn;
    rd_ma    = ma;
    rd_stage = st;
    @(posedge clk);
    #2;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    go(1'b0, 1'b0, '0, 2'd0);
    clr = 1'b0;
  endtask

  // One full stage of 16 bank-0 words from a clean start, edges numbered from 0.
  task automatic t_stage(input string tag);
    for (int e = 0; e < 22; e++) begin
      go(e < 16, 1'b0, AW'(e), 2'd0);
      check({tag, "_wr_en0"}, wr_en0, e >= 4 && e <= 19);
      check({tag, "_stage_done"}, stage_done, e == 19);
      if (e == 19) check({tag, "_wr_stage_hold"}, wr_stage, 0);
      if (e == 20) check({tag, "_wr_stage_next"}, wr_stage, 1);
    end
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  int   acc;
  logic ren, rbn, rclr;
  logic [1:0] rtag;

  initial begin
    rst_n = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_bn = 1'b0; rd_ma = '0; rd_stage = '0;
    #1;
    check("rst_wr_en0", wr_en0, 0);
    check("rst_wr_en1", wr_en1, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_stage_err", stage_err, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single word to bank 1: one strobe exactly LAT edges later.
    go(1'b1, 1'b1, 11'h2A, 2'd0);
    check("t1_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      go(1'b0, 1'b0, '0, 2'd0);
      check("t1_wr_en1", wr_en1, i == 4);
      check("t1_wr_en0", wr_en0, 0);
    end
    check("t1_wr_addr", wr_addr, 11'h2A);
    check("t1_busy_partial", busy, 1);

    do_clr();
    t_stage("t2");

    // Full FFT: four stages of correctly tagged words.
    do_clr();
    for (int e = 0; e < 70; e++) begin
      go(e < 64, 1'($urandom), AW'(e), 2'((e / 16) % 4));
      check("t3_stage_done", stage_done, e == 19 || e == 35 || e == 51 || e == 67);
      check("t3_fft_done", fft_done, e == 67);
      if (e == 67) check("t3_wr_stage_last", wr_stage, 3);
      if (e == 68) check("t3_wr_stage_wrap", wr_stage, 0);
    end
    check("t3_stage_err", stage_err, 0);

    // Wrong tag on word 5 of stage 0: sticky error from its write onward, cleared by clr.
    do_clr();
    for (int e = 0; e < 22; e++) begin
      go(e < 16, 1'b0, AW'(e), (e == 5) ? 2'd2 : 2'd0);
      check("t4_stage_err", stage_err, e >= 9);
    end
    do_clr();
    check("t4_err_clr", stage_err, 0);

    // Flush with words in flight; rd_en alongside clr is dropped.
    for (int e = 0; e < 5; e++) go(1'b1, 1'b0, AW'(e + 100), 2'd0);
    clr = 1'b1;
    go(1'b1, 1'b1, 11'h7FF, 2'd0);
    clr = 1'b0;
    check("t5_busy", busy, 0);
    for (int e = 0; e < 9; e++) begin
      check("t5_no_strobe", wr_en0 | wr_en1, 0);
      go(1'b0, 1'b0, '0, 2'd0);
    end

    // Async reset with wc=7 and words still in flight.
    do_clr();
    for (int e = 0; e < 11; e++) go(e < 10, 1'b1, AW'(e), 2'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en1", wr_en1, 0);
    check("t6_rst_wr_addr", wr_addr, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wr_stage", wr_stage, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    t_stage("t6");

    // Random traffic: mostly correct tags, occasional wrong tag and flush.
    do_clr();
    acc = 0;
    for (int c = 0; c < 1500; c++) begin
      ren  = $urandom_range(0, 9) < 7;
      rbn  = 1'($urandom);
      rclr = $urandom_range(0, 149) == 0;
      rtag = 2'((acc / PTS) % NS);
      if ($urandom_range(0, 59) == 0) rtag = rtag ^ 2'd1;
      clr = rclr;
      go(ren, rbn, AW'($urandom), rtag);
      clr = 1'b0;
      if (rclr) acc = 0;
      else if (ren) acc++;
    end
    for (int c = 0; c < 8; c++) go(1'b0, 1'b0, '0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
